// File: rtl/microwave_ctrl.sv
// ---------------------------------------------------------------------------
// microwave_ctrl
//
// Top-level cooking controller for the microwave. It shifts keypad digits
// into the countdown timer, generates the timer's count pulses through a
// prescaler, watches the timer's zero flag, and owns the magnetron enable,
// the door interlock behaviour and the end-of-cook beeper.
//
// Parameters:
//   TICK_DIV    - clock cycles per timer count pulse (>= 2)
//   BEEP_CYCLES - length of the done beep in clock cycles (>= 1)
//
// Ports:
//   clk          - system clock, everything on the rising edge
//   clrn         - synchronous active-low reset
//   key_valid    - one-cycle strobe, a keypad digit is present
//   key_digit    - keypad value, only 0..9 are legal
//   start        - start/resume request strobe
//   stop         - pause request strobe
//   clear        - cancel/clear request strobe
//   door_closed  - door interlock level, 1 = closed
//   timer_zero   - timer reads 0:00
//   timer_data   - digit presented to the timer
//   timer_loadn  - timer load strobe, active low
//   timer_en     - timer count pulse, active high
//   timer_clrn   - timer clear, active low
//   mag_on       - magnetron enable
//   beep         - done indicator
//   state        - IDLE=0, SETTING=1, COOK=2, PAUSE=3, DONE=4
// ---------------------------------------------------------------------------
module microwave_ctrl #(
    parameter int TICK_DIV    = 10,
    parameter int BEEP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_en,
    output logic       timer_clrn,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);
    localparam logic [BW-1:0] BEEP_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTING = 3'd1,
        COOK    = 3'd2,
        PAUSE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        cur_state;
    logic [1:0]    digit_count;
    logic [PW-1:0] prescaler;
    logic [BW-1:0] beep_cnt;
    logic          key_ok;

    assign state = cur_state;

    // A key is only usable if it is a decimal digit and the timer still has
    // room for it (minutes, tens, ones).
    assign key_ok = key_valid && (key_digit <= 4'd9) && (digit_count < 2'd3);

    // Single-process controller. Pulse outputs (loadn, en, clrn) default to
    // their inactive level every cycle so that each asserted pulse lasts
    // exactly one cycle. Within a state the checks are ordered by event
    // priority: clear, then stop/door, then timer_zero, then start, then keys.
    // Because loads only happen in IDLE/SETTING, count pulses only in COOK and
    // clears only on the clear branch, the three timer strobes never overlap.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            cur_state   <= IDLE;
            timer_loadn <= 1'b1;
            timer_en    <= 1'b0;
            timer_clrn  <= 1'b0;
            mag_on      <= 1'b0;
            beep        <= 1'b0;
            timer_data  <= 4'd0;
            digit_count <= 2'd0;
            prescaler   <= '0;
            beep_cnt    <= '0;
        end else begin
            timer_loadn <= 1'b1;
            timer_en    <= 1'b0;
            timer_clrn  <= 1'b1;

            if (clear) begin
                timer_clrn  <= 1'b0;
                digit_count <= 2'd0;
                prescaler   <= '0;
                beep_cnt    <= '0;
                cur_state   <= IDLE;
                mag_on      <= 1'b0;
                beep        <= 1'b0;
            end else begin
                case (cur_state)
                    IDLE, SETTING: begin
                        if (cur_state == SETTING && start && door_closed && !timer_zero) begin
                            cur_state <= COOK;
                            prescaler <= '0;
                            mag_on    <= 1'b1;
                        end else if (key_ok) begin
                            timer_data  <= key_digit;
                            timer_loadn <= 1'b0;
                            digit_count <= digit_count + 2'd1;
                            cur_state   <= SETTING;
                        end
                    end

                    // The prescaler is deliberately left untouched when
                    // pausing so a resumed cook keeps its partial tick.
                    COOK: begin
                        if (stop || !door_closed) begin
                            cur_state <= PAUSE;
                            mag_on    <= 1'b0;
                        end else if (timer_zero) begin
                            cur_state <= DONE;
                            mag_on    <= 1'b0;
                            beep      <= 1'b1;
                            beep_cnt  <= '0;
                        end else begin
                            mag_on <= 1'b1;
                            if (prescaler == PRE_LAST) begin
                                prescaler <= '0;
                                timer_en  <= 1'b1;
                            end else begin
                                prescaler <= prescaler + PRE_ONE;
                            end
                        end
                    end

                    PAUSE: begin
                        if (start && door_closed && !stop && !timer_zero) begin
                            cur_state <= COOK;
                            mag_on    <= 1'b1;
                        end
                    end

                    // A key press or the door opening acknowledges the beep
                    // early; the key itself is swallowed.
                    DONE: begin
                        if (key_valid || !door_closed || beep_cnt == BEEP_LAST) begin
                            cur_state   <= IDLE;
                            beep        <= 1'b0;
                            digit_count <= 2'd0;
                        end else begin
                            beep_cnt <= beep_cnt + BEEP_ONE;
                        end
                    end

                    default: begin
                        cur_state <= IDLE;
                        mag_on    <= 1'b0;
                        beep      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
